// File: rtl/cr16_controller.sv
// -----------------------------------------------------------------------------
// cr16_controller
//
// Fetch/decode/execute control FSM sitting directly upstream of cr16_datapath.
// Fetches one 16-bit CR16 instruction, decodes it into datapath controls,
// pulses the register/flag write enables and maintains the PC. A new
// instruction completes every three cycles, plus any fetch wait cycles.
//
// Ports:
//   I_CLK, I_RESET     clock and synchronous active-high reset
//   I_ENABLE           global enable; low freezes all state and outputs
//   O_INSTR_REQ, O_PC  fetch request and fetch address
//   I_INSTR_VALID,     returned instruction and its qualifier
//   I_INSTR
//   I_FLAGS            datapath flags {N,Z,F,L,C} = [4:0]
//   O_REG_ENABLE       one-hot register write enable (EXECUTE only)
//   O_READ_PORT_A_SEL  operand A register (Rdest)
//   O_READ_PORT_B_SEL  operand B register (Rsrc, R-type only)
//   O_OPCODE           ALU operation (CR16 opext encoding)
//   O_IMMEDIATE        extended immediate
//   O_IMM_SEL          1 = operand B is O_IMMEDIATE
//   O_FLAG_WE          one-cycle flag capture pulse
//   O_HALTED           high in HALT
//   O_DBG_STATE        current FSM state (FETCH=0, DECODE=1, EXECUTE=2, HALT=3)
//
// Fetch handshake: while in FETCH the controller holds O_INSTR_REQ high with
// O_PC stable; the instruction is accepted on the first rising edge where
// I_INSTR_VALID is high (and I_ENABLE is high). I_INSTR_VALID is ignored in
// every other state. There is no limit on how long the request may wait.
// -----------------------------------------------------------------------------
module cr16_controller #(
    parameter int                  PC_WIDTH = 16,
    parameter logic [PC_WIDTH-1:0] RESET_PC = '0
) (
    input  logic                I_CLK,
    input  logic                I_RESET,
    input  logic                I_ENABLE,
    output logic                O_INSTR_REQ,
    output logic [PC_WIDTH-1:0] O_PC,
    input  logic                I_INSTR_VALID,
    input  logic [15:0]         I_INSTR,
    input  logic [4:0]          I_FLAGS,
    output logic [15:0]         O_REG_ENABLE,
    output logic [3:0]          O_READ_PORT_A_SEL,
    output logic [3:0]          O_READ_PORT_B_SEL,
    output logic [3:0]          O_OPCODE,
    output logic [15:0]         O_IMMEDIATE,
    output logic                O_IMM_SEL,
    output logic                O_FLAG_WE,
    output logic                O_HALTED,
    output logic [1:0]          O_DBG_STATE
);

    typedef enum logic [1:0] {
        S_FETCH   = 2'd0,
        S_DECODE  = 2'd1,
        S_EXECUTE = 2'd2,
        S_HALT    = 2'd3
    } state_t;

    state_t              state, state_nxt;
    logic [PC_WIDTH-1:0] pc, pc_nxt;
    logic [15:0]         instr;

    // ---------------------------------------------------------------- state
    always_ff @(posedge I_CLK) begin
        if (I_RESET) begin
            state <= S_FETCH;
            pc    <= RESET_PC;
            instr <= '0;
        end else if (I_ENABLE) begin
            state <= state_nxt;
            pc    <= pc_nxt;
            if (state == S_FETCH && I_INSTR_VALID) begin
                instr <= I_INSTR;
            end
        end
    end

    // --------------------------------------------------------------- decode
    function automatic logic is_alu_code(input logic [3:0] code);
        return (code == 4'b0101) || (code == 4'b1001) || (code == 4'b1011) ||
               (code == 4'b0001) || (code == 4'b0010) || (code == 4'b0011) ||
               (code == 4'b1101);
    endfunction

    logic [3:0]          f_op, f_rd, f_ext, f_rs;
    logic [7:0]          f_imm8;
    logic                is_r, is_i, is_lui, is_br, is_alu, is_cmp, legal;
    logic                taken;
    logic [3:0]          dec_opcode, dec_b;
    logic [15:0]         dec_imm;
    logic                dec_imm_sel;
    logic [PC_WIDTH-1:0] disp_ext;
    logic                unused_flag_l;

    assign f_op   = instr[15:12];
    assign f_rd   = instr[11:8];
    assign f_ext  = instr[7:4];
    assign f_rs   = instr[3:0];
    assign f_imm8 = instr[7:0];

    assign is_r   = (f_op == 4'b0000) && is_alu_code(f_ext);
    assign is_i   = is_alu_code(f_op);
    assign is_lui = (f_op == 4'b1111);
    assign is_br  = (f_op == 4'b1100);
    assign is_alu = is_r || is_i || is_lui;
    assign is_cmp = (is_r && f_ext == 4'b1011) || (is_i && f_op == 4'b1011);
    assign legal  = is_alu || is_br;

    assign disp_ext      = {{(PC_WIDTH-8){f_imm8[7]}}, f_imm8};
    // The L flag has no branch condition that reads it.
    assign unused_flag_l = I_FLAGS[1];

    // Branch condition on {N,Z,F,L,C}; unlisted conditions are never taken.
    always_comb begin
        taken = 1'b0;
        case (f_rd)
            4'b0000: taken =  I_FLAGS[3];
            4'b0001: taken = !I_FLAGS[3];
            4'b0010: taken =  I_FLAGS[0];
            4'b0011: taken = !I_FLAGS[0];
            4'b0100: taken =  I_FLAGS[2];
            4'b0101: taken = !I_FLAGS[2];
            4'b0110: taken =  I_FLAGS[4];
            4'b0111: taken = !I_FLAGS[4];
            4'b1101: taken =  I_FLAGS[4] | I_FLAGS[3];
            4'b1110: taken =  1'b1;
            default: taken =  1'b0;
        endcase
    end

    always_comb begin
        dec_opcode  = 4'b0000;
        dec_b       = 4'b0000;
        dec_imm     = 16'h0000;
        dec_imm_sel = 1'b0;
        if (is_r) begin
            dec_opcode = f_ext;
            dec_b      = f_rs;
        end else if (is_i) begin
            dec_opcode  = f_op;
            dec_imm_sel = 1'b1;
            // ADDI/SUBI/CMPI sign-extend; logic ops and MOVI zero-extend.
            if (f_op == 4'b0101 || f_op == 4'b1001 || f_op == 4'b1011) begin
                dec_imm = {{8{f_imm8[7]}}, f_imm8};
            end else begin
                dec_imm = {8'h00, f_imm8};
            end
        end else if (is_lui) begin
            dec_opcode  = 4'b1101;
            dec_imm     = {f_imm8, 8'h00};
            dec_imm_sel = 1'b1;
        end
    end

    // ------------------------------------------------ next state / outputs
    always_comb begin
        state_nxt         = state;
        pc_nxt            = pc;
        O_INSTR_REQ       = 1'b0;
        O_PC              = pc;
        O_REG_ENABLE      = 16'h0000;
        O_READ_PORT_A_SEL = 4'h0;
        O_READ_PORT_B_SEL = 4'h0;
        O_OPCODE          = 4'h0;
        O_IMMEDIATE       = 16'h0000;
        O_IMM_SEL         = 1'b0;
        O_FLAG_WE         = 1'b0;
        O_HALTED          = 1'b0;
        O_DBG_STATE       = state;

        case (state)
            S_FETCH: begin
                O_INSTR_REQ = 1'b1;
                if (I_INSTR_VALID) begin
                    state_nxt = S_DECODE;
                end
            end
            S_DECODE: begin
                O_READ_PORT_A_SEL = is_alu ? f_rd : 4'h0;
                O_READ_PORT_B_SEL = dec_b;
                O_OPCODE          = dec_opcode;
                O_IMMEDIATE       = dec_imm;
                O_IMM_SEL         = dec_imm_sel;
                state_nxt         = legal ? S_EXECUTE : S_HALT;
            end
            S_EXECUTE: begin
                O_READ_PORT_A_SEL = is_alu ? f_rd : 4'h0;
                O_READ_PORT_B_SEL = dec_b;
                O_OPCODE          = dec_opcode;
                O_IMMEDIATE       = dec_imm;
                O_IMM_SEL         = dec_imm_sel;
                if (is_alu) begin
                    O_FLAG_WE = 1'b1;
                    if (!is_cmp) begin
                        O_REG_ENABLE = 16'd1 << f_rd;
                    end
                end
                pc_nxt    = (is_br && taken) ? pc + disp_ext : pc + PC_WIDTH'(1);
                state_nxt = S_FETCH;
            end
            S_HALT: begin
                O_HALTED = 1'b1;
            end
            default: begin
                state_nxt = S_HALT;
            end
        endcase

        // The reset cycle itself shows the reset values, whatever the state.
        if (I_RESET) begin
            O_INSTR_REQ       = 1'b0;
            O_PC              = RESET_PC;
            O_REG_ENABLE      = 16'h0000;
            O_READ_PORT_A_SEL = 4'h0;
            O_READ_PORT_B_SEL = 4'h0;
            O_OPCODE          = 4'h0;
            O_IMMEDIATE       = 16'h0000;
            O_IMM_SEL         = 1'b0;
            O_FLAG_WE         = 1'b0;
            O_HALTED          = 1'b0;
        end
    end

endmodule

// File: doc/cr16_controller.md
Name: cr16_controller

Overview:
- Fetch/decode/execute control FSM that sits directly upstream of cr16_datapath.
- Fetches 16-bit CR16 instructions over a request/valid handshake and decodes them.
- Drives the datapath's register write enables, read-port selects, ALU opcode and immediate.
- Consumes the datapath flags to resolve conditional branches and maintains the PC.

Parameters:
- PC_WIDTH, 16, width of the program counter / instruction address.
- RESET_PC, 0, PC value loaded on reset.

Ports:
- I_CLK  input  1  system clock; all state updates on rising edge.
- I_RESET  input  1  synchronous, active-high reset.
- I_ENABLE  input  1  global enable; when low, all state and outputs hold.
- O_INSTR_REQ  output  1  instruction fetch request.
- O_PC  output  PC_WIDTH  fetch address.
- I_INSTR_VALID  input  1  I_INSTR valid this cycle.
- I_INSTR  input  16  fetched instruction.
- I_FLAGS  input  5  datapath flag register {N,Z,F,L,C} = bits [4:0].
- O_REG_ENABLE  output  16  one-hot register write enable to datapath.
- O_READ_PORT_A_SEL  output  4  register index, ALU operand A (Rdest).
- O_READ_PORT_B_SEL  output  4  register index, ALU operand B (Rsrc).
- O_OPCODE  output  4  ALU operation (CR16 opext encoding).
- O_IMMEDIATE  output  16  extended immediate.
- O_IMM_SEL  output  1  1 selects O_IMMEDIATE as operand B.
- O_FLAG_WE  output  1  one-cycle pulse; datapath captures flags.
- O_HALTED  output  1  high in HALT state.

Behaviour:
- Clock is I_CLK; reset is I_RESET, synchronous and active-high; single clock domain.
- Encoding: [15:12] op, [11:8] Rdest/cond, [7:4] opext or imm[7:4], [3:0] Rsrc or imm[3:0].
- R-type (op=0000): opext ∈ {0101 ADD, 1001 SUB, 1011 CMP, 0001 AND, 0010 OR, 0011 XOR, 1101 MOV}; operand B = Rsrc.
- I-type: op ∈ the same set; O_OPCODE = op; imm8 = [7:0].
  - ADDI, SUBI, CMPI: imm8 sign-extended.
  - ANDI, ORI, XORI, MOVI: imm8 zero-extended.
- LUI (op=1111): O_OPCODE = 1101 (MOV), O_IMMEDIATE = {imm8, 8'h00}.
- Bcond (op=1100): cond = [11:8], disp = sign-extended [7:0].
  - 0000 EQ: Z. 0001 NE: !Z. 0010 CS: C. 0011 CC: !C.
  - 0100 FS: F. 0101 FC: !F. 0110 GT: N. 0111 LE: !N.
  - 1101 GE: N|Z. 1110 UC: always taken. Any other cond: not taken.
- Any other op or opext: illegal; FSM goes to HALT.
- FSM states: FETCH, DECODE, EXECUTE, HALT.
  - FETCH: O_INSTR_REQ=1, O_PC=PC. On I_INSTR_VALID, latch I_INSTR and go to DECODE. Otherwise wait indefinitely.
  - DECODE: drive selects, O_OPCODE, O_IMMEDIATE, O_IMM_SEL. O_REG_ENABLE=0. Go to EXECUTE, or HALT if illegal.
  - EXECUTE: decode outputs held. For non-CMP ALU ops, O_REG_ENABLE = 1<<Rdest for exactly one cycle. All ALU ops incl. CMP pulse O_FLAG_WE. Bcond evaluates I_FLAGS this cycle with no enables. PC <= PC+disp if taken, else PC+1, modulo 2^PC_WIDTH. Go to FETCH.
  - HALT: all enables 0, O_HALTED=1; exits only on reset.
- Throughput: one instruction per 3 cycles, plus fetch wait cycles.
- Reset values: PC=RESET_PC, state=FETCH, O_REG_ENABLE=0, O_FLAG_WE=0, O_IMM_SEL=0, O_OPCODE=0, O_IMMEDIATE=0, selects=0, O_HALTED=0, O_INSTR_REQ=0 in the reset cycle.
- Reset mid-instruction abandons it; no write enable asserts in the cycle after reset.
- I_ENABLE low freezes state, PC and every output, including a pending EXECUTE enable, which stays asserted.
- I_RESET has priority over I_ENABLE.
- I_INSTR_VALID outside FETCH is ignored.
- O_REG_ENABLE is never non-one-hot. Writes to any register, including r0, are allowed.

Test Plan:
- Reset, then MOVI r1,#1 (0xD101) returned with valid after 2 wait cycles -> REQ high 3 cycles; O_REG_ENABLE=0x0002, O_IMMEDIATE=0x0001, O_IMM_SEL=1, O_OPCODE=1101 in EXECUTE; PC 0->1.
- ADD r2,r1 (0x0251) -> READ_A=2, READ_B=1, O_OPCODE=0101, O_IMM_SEL=0, O_REG_ENABLE=0x0004 for one cycle, O_FLAG_WE pulse.
- ADDI r3,#-2 (0x53FE) -> O_IMMEDIATE=0xFFFE; LUI r4,#0xAB (0xF4AB) -> O_IMMEDIATE=0xAB00, O_REG_ENABLE=0x0010.
- CMP r1,r2 (0x01B2) -> O_FLAG_WE pulse, O_REG_ENABLE=0. Then BEQ -3 (0xC0FD) at PC=10: I_FLAGS=5'b01000 -> PC=7; I_FLAGS=0 -> PC=11.
- Illegal 0x8000 -> O_HALTED=1 after DECODE; REQ and enables stay 0 for 20 cycles; I_RESET -> PC=RESET_PC, FETCH.
- I_ENABLE dropped 4 cycles during EXECUTE of ADD -> O_REG_ENABLE held at 0x0004, PC unchanged until re-enabled. Reset asserted in EXECUTE -> enables 0 the next cycle.
